// File: rtl/neuron_cfg_pkg.sv
// Shared constants and state encoding for the ALIF neuron parameter sequencer.
// Payload slot indices follow the on-wire byte order after the header.
package neuron_cfg_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int         NUM_PAYLOAD = 6;

  localparam logic [2:0] P_WEIGHT = 3'd0;
  localparam logic [2:0] P_LEAK1  = 3'd1;
  localparam logic [2:0] P_LEAK2  = 3'd2;
  localparam logic [2:0] P_THRESH = 3'd3;
  localparam logic [2:0] P_CYCLES = 3'd4;
  localparam logic [2:0] P_SDIV   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RUN    = 2'd3
  } seq_state_t;

  function automatic logic is_last_payload(input logic [2:0] idx);
    return (idx == P_SDIV);
  endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// Programmable input-sample strobe: one pulse per (sample_div+1) enabled cycles.
// The enable input is the value neuron_enable takes on the same edge, so the strobe lines up with it.
module sample_strobe_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_div,
  input  logic       enable,
  input  logic       clear,
  output logic       strobe
);

  logic [7:0] cnt_r;
  logic       strobe_r;

  // Divider counter; holds its phase while the neuron is not enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= 8'd0;
      strobe_r <= 1'b0;
    end else if (clear) begin
      cnt_r    <= 8'd0;
      strobe_r <= 1'b0;
    end else if (enable) begin
      if (cnt_r == sample_div) begin
        cnt_r    <= 8'd0;
        strobe_r <= 1'b1;
      end else begin
        cnt_r    <= cnt_r + 8'd1;
        strobe_r <= 1'b0;
      end
    end else begin
      cnt_r    <= cnt_r;
      strobe_r <= 1'b0;
    end
  end

  assign strobe = strobe_r;

endmodule

// File: rtl/alif_param_sequencer.sv
// Framed configuration loader and run sequencer for one ALIF dual-leak neuron.
// Parameters land in a shadow bank and are committed to the active bank on a single edge.
module alif_param_sequencer
  import neuron_cfg_pkg::*;
#(
  parameter logic [7:0] HDR     = HDR_DEFAULT,
  parameter int         TIMEOUT = 255,
  parameter int         TO_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cfg_byte,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       run_en,
  input  logic       cfg_err_clr,
  output logic [2:0] weight_a,
  output logic [7:0] leak_rate_1,
  output logic [7:0] leak_rate_2,
  output logic [7:0] threshold_min,
  output logic [3:0] leak_cycles_1,
  output logic [3:0] leak_cycles_2,
  output logic       params_ready,
  output logic       neuron_reset,
  output logic       neuron_enable,
  output logic       neuron_input_enable,
  output logic       cfg_err,
  output logic [1:0] state_out
);

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);
  localparam logic [TO_BITS-1:0] TO_ZERO = {TO_BITS{1'b0}};
  localparam logic [TO_BITS-1:0] TO_ONE  = TO_BITS'(1);

  seq_state_t         state_r;
  logic [2:0]         idx_r;
  logic [TO_BITS-1:0] to_cnt_r;

  logic [2:0] sh_weight_r;
  logic [7:0] sh_leak1_r;
  logic [7:0] sh_leak2_r;
  logic [7:0] sh_thresh_r;
  logic [3:0] sh_cyc1_r;
  logic [3:0] sh_cyc2_r;
  logic [7:0] sh_sdiv_r;

  logic [2:0] weight_a_r;
  logic [7:0] leak_rate_1_r;
  logic [7:0] leak_rate_2_r;
  logic [7:0] threshold_min_r;
  logic [3:0] leak_cycles_1_r;
  logic [3:0] leak_cycles_2_r;
  logic [7:0] sample_div_r;

  logic cfg_ready_r;
  logic params_ready_r;
  logic neuron_reset_r;
  logic neuron_enable_r;
  logic cfg_err_r;

  logic accept_s;
  logic is_hdr_s;
  logic idle_or_run_s;
  logic timeout_s;
  logic err_set_s;
  logic commit_s;
  logic enable_next_s;
  logic strobe_s;

  assign accept_s      = cfg_valid & cfg_ready_r;
  assign is_hdr_s      = (cfg_byte == HDR);
  assign idle_or_run_s = (state_r == ST_IDLE) || (state_r == ST_RUN);
  assign timeout_s     = (state_r == ST_LOAD) && !accept_s && (to_cnt_r == TO_LAST);
  assign err_set_s     = (idle_or_run_s && accept_s && !is_hdr_s) || timeout_s;
  assign commit_s      = (state_r == ST_COMMIT);
  // params_ready and neuron_reset both rise on the commit edge, so enable stays low that cycle.
  assign enable_next_s = params_ready_r & run_en & ~commit_s;

  // Framing FSM, shadow/active banks, timeout counter and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      idx_r           <= 3'd0;
      to_cnt_r        <= TO_ZERO;
      sh_weight_r     <= 3'd0;
      sh_leak1_r      <= 8'd0;
      sh_leak2_r      <= 8'd0;
      sh_thresh_r     <= 8'd0;
      sh_cyc1_r       <= 4'd0;
      sh_cyc2_r       <= 4'd0;
      sh_sdiv_r       <= 8'd0;
      weight_a_r      <= 3'd0;
      leak_rate_1_r   <= 8'd0;
      leak_rate_2_r   <= 8'd0;
      threshold_min_r <= 8'd0;
      leak_cycles_1_r <= 4'd0;
      leak_cycles_2_r <= 4'd0;
      sample_div_r    <= 8'd0;
      cfg_ready_r     <= 1'b1;
      params_ready_r  <= 1'b0;
      neuron_reset_r  <= 1'b0;
      neuron_enable_r <= 1'b0;
      cfg_err_r       <= 1'b0;
    end else begin
      cfg_ready_r     <= 1'b1;
      neuron_reset_r  <= 1'b0;
      neuron_enable_r <= enable_next_s;
      cfg_err_r       <= err_set_s | (cfg_err_r & ~cfg_err_clr);
      case (state_r)
        ST_IDLE, ST_RUN: begin
          if (accept_s && is_hdr_s) begin
            state_r  <= ST_LOAD;
            idx_r    <= 3'd0;
            to_cnt_r <= TO_ZERO;
          end else begin
            state_r  <= state_r;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            case (idx_r)
              P_WEIGHT: sh_weight_r <= cfg_byte[2:0];
              P_LEAK1:  sh_leak1_r  <= cfg_byte;
              P_LEAK2:  sh_leak2_r  <= cfg_byte;
              P_THRESH: sh_thresh_r <= cfg_byte;
              P_CYCLES: begin
                sh_cyc2_r <= cfg_byte[7:4];
                sh_cyc1_r <= cfg_byte[3:0];
              end
              P_SDIV:   sh_sdiv_r   <= cfg_byte;
              default:  sh_sdiv_r   <= sh_sdiv_r;
            endcase
            idx_r    <= idx_r + 3'd1;
            to_cnt_r <= TO_ZERO;
            if (is_last_payload(idx_r)) begin
              state_r     <= ST_COMMIT;
              cfg_ready_r <= 1'b0;
            end else begin
              state_r     <= ST_LOAD;
            end
          end else if (to_cnt_r == TO_LAST) begin
            // Abandoned frame: drop the partial shadow and fall back to the prior mode.
            sh_weight_r <= 3'd0;
            sh_leak1_r  <= 8'd0;
            sh_leak2_r  <= 8'd0;
            sh_thresh_r <= 8'd0;
            sh_cyc1_r   <= 4'd0;
            sh_cyc2_r   <= 4'd0;
            sh_sdiv_r   <= 8'd0;
            idx_r       <= 3'd0;
            to_cnt_r    <= TO_ZERO;
            state_r     <= params_ready_r ? ST_RUN : ST_IDLE;
          end else begin
            to_cnt_r    <= to_cnt_r + TO_ONE;
          end
        end
        ST_COMMIT: begin
          weight_a_r      <= sh_weight_r;
          leak_rate_1_r   <= sh_leak1_r;
          leak_rate_2_r   <= sh_leak2_r;
          threshold_min_r <= sh_thresh_r;
          leak_cycles_1_r <= sh_cyc1_r;
          leak_cycles_2_r <= sh_cyc2_r;
          sample_div_r    <= sh_sdiv_r;
          params_ready_r  <= 1'b1;
          neuron_reset_r  <= 1'b1;
          state_r         <= ST_RUN;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  sample_strobe_gen u_strobe (
    .clk        (clk),
    .reset      (reset),
    .sample_div (sample_div_r),
    .enable     (enable_next_s),
    .clear      (commit_s),
    .strobe     (strobe_s)
  );

  assign cfg_ready           = cfg_ready_r;
  assign weight_a            = weight_a_r;
  assign leak_rate_1         = leak_rate_1_r;
  assign leak_rate_2         = leak_rate_2_r;
  assign threshold_min       = threshold_min_r;
  assign leak_cycles_1       = leak_cycles_1_r;
  assign leak_cycles_2       = leak_cycles_2_r;
  assign params_ready        = params_ready_r;
  assign neuron_reset        = neuron_reset_r;
  assign neuron_enable       = neuron_enable_r;
  assign neuron_input_enable = strobe_s;
  assign cfg_err             = cfg_err_r;
  assign state_out           = state_r;

endmodule

// File: tb/tb_alif_param_sequencer.sv
// Self-checking bench for alif_param_sequencer: committed parameter sets are
// queued as frames are sent and popped when the neuron_reset pulse appears.
module tb_alif_param_sequencer;

  typedef struct packed {
    logic [2:0] w;
    logic [7:0] l1;
    logic [7:0] l2;
    logic [7:0] th;
    logic [3:0] c2;
    logic [3:0] c1;
    logic [7:0] div;
  } params_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cfg_byte = 8'h00;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic       run_en = 1'b1;
  logic       cfg_err_clr = 1'b0;
  logic [2:0] weight_a;
  logic [7:0] leak_rate_1;
  logic [7:0] leak_rate_2;
  logic [7:0] threshold_min;
  logic [3:0] leak_cycles_1;
  logic [3:0] leak_cycles_2;
  logic       params_ready;
  logic       neuron_reset;
  logic       neuron_enable;
  logic       neuron_input_enable;
  logic       cfg_err;
  logic [1:0] state_out;

  int      errors = 0;
  int      checks = 0;
  int      k = 0;
  int      div_m = 0;
  params_t exp_q[$];
  params_t cur;
  logic [34:0] obs_v;
  logic [34:0] exp_v;

  always #5 clk = ~clk;

  alif_param_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .cfg_byte            (cfg_byte),
    .cfg_valid           (cfg_valid),
    .cfg_ready           (cfg_ready),
    .run_en              (run_en),
    .cfg_err_clr         (cfg_err_clr),
    .weight_a            (weight_a),
    .leak_rate_1         (leak_rate_1),
    .leak_rate_2         (leak_rate_2),
    .threshold_min       (threshold_min),
    .leak_cycles_1       (leak_cycles_1),
    .leak_cycles_2       (leak_cycles_2),
    .params_ready        (params_ready),
    .neuron_reset        (neuron_reset),
    .neuron_enable       (neuron_enable),
    .neuron_input_enable (neuron_input_enable),
    .cfg_err             (cfg_err),
    .state_out           (state_out)
  );

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    cfg_byte  = b;
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: cfg_ready=%b required 1", cfg_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] payload);
    params_t e;
    e.w   = payload[42:40];
    e.l1  = payload[39:32];
    e.l2  = payload[31:24];
    e.th  = payload[23:16];
    e.c2  = payload[15:12];
    e.c1  = payload[11:8];
    e.div = payload[7:0];
    exp_q.push_back(e);
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_byte(payload[47-8*i -: 8]);
  endtask

  // Entered at the negedge of the COMMIT cycle.
  task automatic check_commit(input logic prev_en, input logic run_during);
    params_t e;
    checks++;
    if (state_out !== 2'd2 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL commit_state: state=%0d ready=%b required 2/0", state_out, cfg_ready);
    end
    obs_v = {weight_a, leak_rate_1, leak_rate_2, threshold_min, leak_cycles_2, leak_cycles_1};
    exp_v = {cur.w, cur.l1, cur.l2, cur.th, cur.c2, cur.c1};
    checks++;
    if (obs_v !== exp_v || neuron_enable !== prev_en) begin
      errors++;
      $display("FAIL commit_old: params=%h en=%b required %h/%b", obs_v, neuron_enable, exp_v, prev_en);
    end
    run_en = run_during;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty at commit, required one entry");
    end else begin
      e = exp_q.pop_front();
      obs_v = {weight_a, leak_rate_1, leak_rate_2, threshold_min, leak_cycles_2, leak_cycles_1};
      exp_v = {e.w, e.l1, e.l2, e.th, e.c2, e.c1};
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL commit_params: got %h required %h", obs_v, exp_v);
      end
      cur   = e;
      div_m = int'(e.div);
    end
    checks++;
    if (neuron_reset !== 1'b1 || neuron_enable !== 1'b0 || neuron_input_enable !== 1'b0 ||
        params_ready !== 1'b1 || state_out !== 2'd3 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL commit_pulse: rst=%b en=%b ie=%b pr=%b st=%0d rdy=%b required 1/0/0/1/3/1",
               neuron_reset, neuron_enable, neuron_input_enable, params_ready, state_out, cfg_ready);
    end
    @(negedge clk);
    k = run_during ? 1 : 0;
    checks++;
    if (neuron_reset !== 1'b0 || neuron_enable !== run_during ||
        neuron_input_enable !== (run_during && (k % (div_m + 1)) == 0)) begin
      errors++;
      $display("FAIL post_commit: rst=%b en=%b ie=%b required 0/%b/%b", neuron_reset,
               neuron_enable, neuron_input_enable, run_during, (run_during && (k % (div_m + 1)) == 0));
    end
  endtask

  task automatic run_cycles(input int n, input logic en);
    logic exp_ie;
    for (int i = 0; i < n; i++) begin
      run_en = en;
      @(negedge clk);
      if (en) k++;
      exp_ie = en && ((k % (div_m + 1)) == 0);
      checks++;
      if (neuron_enable !== en || neuron_input_enable !== exp_ie) begin
        errors++;
        $display("FAIL run_cycle k=%0d: en=%b ie=%b required %b/%b", k, neuron_enable,
                 neuron_input_enable, en, exp_ie);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({weight_a, leak_rate_1, leak_rate_2, threshold_min, leak_cycles_1, leak_cycles_2,
         params_ready, neuron_reset, neuron_enable, neuron_input_enable, cfg_err, state_out} !== 46'd0 ||
        cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: outputs not cleared (st=%0d pr=%b en=%b err=%b rdy=%b) required zeros and ready=1",
               tag, state_out, params_ready, neuron_enable, cfg_err, cfg_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur = '0;
    check_reset_outputs("reset_state");
  endtask

  task automatic test_idle_error();
    send_byte(8'h11);
    checks++;
    if (cfg_err !== 1'b1 || state_out !== 2'd0) begin
      errors++;
      $display("FAIL idle_drop: err=%b st=%0d required 1/0", cfg_err, state_out);
    end
    cfg_err_clr = 1'b1;
    @(negedge clk);
    cfg_err_clr = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b required 0", cfg_err);
    end
    cfg_err_clr = 1'b1;
    send_byte(8'h22);
    cfg_err_clr = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL err_wins: err=%b required 1", cfg_err);
    end
    cfg_err_clr = 1'b1;
    @(negedge clk);
    cfg_err_clr = 1'b0;
    checks++;
    if (cfg_err !== 1'b0 || state_out !== 2'd0) begin
      errors++;
      $display("FAIL err_clear2: err=%b st=%0d required 0/0", cfg_err, state_out);
    end
  endtask

  task automatic test_basic_commit();
    run_en = 1'b1;
    send_frame(48'h05_10_20_40_32_00);
    check_commit(1'b0, 1'b1);
    run_cycles(6, 1'b1);
  endtask

  task automatic test_sample_div();
    send_frame(48'h01_02_03_04_11_03);
    check_commit(1'b1, 1'b1);
    run_cycles(10, 1'b1);
    run_cycles(5, 1'b0);
    run_cycles(10, 1'b1);
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h77);
    send_byte(8'h66);
    send_byte(8'h55);
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      checks++;
      if (neuron_enable !== 1'b1) begin
        errors++;
        $display("FAIL timeout_enable cycle %0d: en=%b required 1", i, neuron_enable);
      end
      if (i == 254) begin
        checks++;
        if (state_out !== 2'd1 || cfg_err !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early: st=%0d err=%b required 1/0", state_out, cfg_err);
        end
      end
    end
    obs_v = {weight_a, leak_rate_1, leak_rate_2, threshold_min, leak_cycles_2, leak_cycles_1};
    exp_v = {cur.w, cur.l1, cur.l2, cur.th, cur.c2, cur.c1};
    checks++;
    if (state_out !== 2'd3 || cfg_err !== 1'b1 || params_ready !== 1'b1 || obs_v !== exp_v) begin
      errors++;
      $display("FAIL timeout_abort: st=%0d err=%b pr=%b params=%h required 3/1/1/%h",
               state_out, cfg_err, params_ready, obs_v, exp_v);
    end
    cfg_err_clr = 1'b1;
    @(negedge clk);
    cfg_err_clr = 1'b0;
  endtask

  task automatic test_reload();
    send_frame(48'hFE_0A_0B_20_54_01);
    check_commit(1'b1, 1'b1);
    run_cycles(6, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cur = '0;
    check_reset_outputs("reset_mid_load");
    run_en = 1'b1;
    send_frame(48'hA5_A5_07_08_21_02);
    check_commit(1'b0, 1'b0);
    run_cycles(3, 1'b0);
    run_cycles(7, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_error();
    test_basic_commit();
    test_sample_div();
    test_timeout();
    test_reload();
    test_reset_mid_load();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
